// File: rtl/seg_scan_ctrl_if.sv
// Read handshake between the display controller and the data-memory port arbiter.
// The arbiter answers a held request with a grant; read data is valid in the grant cycle.
interface seg_scan_ctrl_if;
   logic        mem_req;
   logic [5:0]  mem_addr;
   logic        mem_gnt;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_gnt,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_gnt,
      output mem_rdata
   );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Seven-segment display controller: fetches one memory word at the switch address and
// time-multiplexes its selected 16-bit half across four active-low digits.
module seg_scan_ctrl #(
   parameter int REFRESH_DIV    = 16,
   parameter int REFETCH_FRAMES = 4
) (
   input  logic                  clk_,
   input  logic                  rst_n,
   input  logic [5:0]            swaddr,
   input  logic                  printhl,
   seg_scan_ctrl_if.master       mem,
   output logic [7:0]            printsig,
   output logic [3:0]            segslct
);

   localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam int FRM_W = $clog2(REFETCH_FRAMES + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
   localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(REFETCH_FRAMES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic              launch;
   logic              grant;
   logic              req_c;
   logic              fetch_pending;
   logic [5:0]        addr_q;
   logic [31:0]       word;
   logic [DIV_W-1:0]  div_cnt;
   logic [1:0]        idx;
   logic [FRM_W-1:0]  frame_cnt;
   logic              slot_end;
   logic              frame_end;
   logic              frame_hit;
   logic              addr_changed;
   logic [15:0]       half;
   logic [3:0]        nibble;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
      logic [6:0] seg;
      seg = 7'h7F;
      case (value)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
         default: seg = 7'h7F;
      endcase
      return seg;
   endfunction

   always_ff @(posedge clk_ or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A grant is only honoured while the request is actually being presented.
   always_comb begin
      state_d = state_q;
      launch  = 1'b0;
      grant   = 1'b0;
      req_c   = 1'b0;
      case (state_q)
         IDLE: begin
            if (fetch_pending) begin
               state_d = REQ;
               launch  = 1'b1;
            end
         end
         REQ: begin
            req_c = 1'b1;
            if (mem.mem_gnt) begin
               state_d = IDLE;
               grant   = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign mem.mem_req  = req_c;
   assign mem.mem_addr = addr_q;

   always_ff @(posedge clk_ or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= 6'd0;
      end else if (launch) begin
         addr_q <= swaddr;
      end
   end

   assign addr_changed = (swaddr != addr_q);

   // Launching already samples the live switch address, so a mismatch seen in that
   // same cycle must not queue a redundant second fetch.
   always_ff @(posedge clk_ or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pending <= 1'b1;
      end else if (launch) begin
         fetch_pending <= 1'b0;
      end else if (addr_changed || frame_hit) begin
         fetch_pending <= 1'b1;
      end
   end

   always_ff @(posedge clk_ or negedge rst_n) begin
      if (!rst_n) begin
         word <= 32'd0;
      end else if (grant) begin
         word <= mem.mem_rdata;
      end
   end

   assign slot_end  = (div_cnt == DIV_LAST);
   assign frame_end = slot_end && (idx == 2'd3);
   assign frame_hit = frame_end && (frame_cnt == FRM_LAST);

   always_ff @(posedge clk_ or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt   <= '0;
         idx       <= 2'd0;
         frame_cnt <= '0;
      end else begin
         div_cnt <= slot_end ? '0 : div_cnt + DIV_W'(1);
         if (slot_end) begin
            idx <= idx + 2'd1;
         end
         if (frame_end) begin
            frame_cnt <= frame_hit ? '0 : frame_cnt + FRM_W'(1);
         end
      end
   end

   assign half   = printhl ? word[31:16] : word[15:0];
   assign nibble = half[{idx, 2'b00} +: 4];

   always_ff @(posedge clk_ or negedge rst_n) begin
      if (!rst_n) begin
         printsig <= 8'hFF;
         segslct  <= 4'hF;
      end else begin
         printsig <= {1'b1, hex_to_seg(nibble)};
         segslct  <= ~(4'b0001 << idx);
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: reset, scan/decode, delayed grant, address change
// during a request, periodic refetch and asynchronous reset in mid-scan.
module tb_seg_scan_ctrl;

   logic        clk_;
   logic        rst_n;
   logic [5:0]  swaddr;
   logic        printhl;
   logic [7:0]  printsig;
   logic [3:0]  segslct;
   int          checks;
   int          errors;

   seg_scan_ctrl_if mem_bus ();

   seg_scan_ctrl #(
      .REFRESH_DIV    (4),
      .REFETCH_FRAMES (2)
   ) dut (
      .clk_     (clk_),
      .rst_n    (rst_n),
      .swaddr   (swaddr),
      .printhl  (printhl),
      .mem      (mem_bus),
      .printsig (printsig),
      .segslct  (segslct)
   );

   initial clk_ = 1'b0;
   always #5 clk_ = ~clk_;

   task automatic tick(input int n);
      repeat (n) @(posedge clk_);
      #2;
   endtask

   task automatic apply_stimulus(input logic [5:0] addr, input logic hl,
                                 input logic gnt, input logic [31:0] rdata);
      swaddr            = addr;
      printhl           = hl;
      mem_bus.mem_gnt   = gnt;
      mem_bus.mem_rdata = rdata;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic check_display(input string tag, input logic [7:0] seg,
                                input logic [3:0] sel);
      check_output({tag, "_printsig"}, 32'(printsig), 32'(seg));
      check_output({tag, "_segslct"}, 32'(segslct), 32'(sel));
   endtask

   task automatic check_mem(input string tag, input logic req, input logic [5:0] addr);
      check_output({tag, "_req"}, 32'(mem_bus.mem_req), 32'(req));
      check_output({tag, "_addr"}, 32'(mem_bus.mem_addr), 32'(addr));
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      apply_stimulus(6'd2, 1'b0, 1'b1, 32'h1234ABCD);

      #12;
      check_display("reset", 8'hFF, 4'hF);
      check_mem("reset", 1'b0, 6'd0);
      rst_n = 1'b1;

      // Edge 1 launches the fetch; edge 2 takes the grant.
      tick(1);
      check_mem("first_req", 1'b1, 6'd2);
      check_display("first_digit_old_word", 8'hC0, 4'hE);
      tick(1);
      check_mem("first_grant", 1'b0, 6'd2);

      // Low half 0xABCD: digits D, C, B, A.
      tick(1);
      check_display("lo_d0", 8'hA1, 4'hE);
      tick(2);
      check_display("lo_d1", 8'hC6, 4'hD);
      tick(4);
      check_display("lo_d2", 8'h83, 4'hB);
      tick(4);
      check_display("lo_d3", 8'h88, 4'h7);

      // High half 0x1234 shows on the very next clock.
      apply_stimulus(6'd2, 1'b1, 1'b1, 32'h1234ABCD);
      tick(1);
      check_display("hi_switch", 8'hF9, 4'h7);
      tick(3);
      check_display("hi_d0", 8'h99, 4'hE);
      tick(4);
      check_display("hi_d1", 8'hB0, 4'hD);
      tick(4);
      check_display("hi_d2", 8'hA4, 4'hB);

      // Withheld grant on a new address: request holds, display keeps the old word.
      apply_stimulus(6'd7, 1'b1, 1'b0, 32'h1234ABCD);
      tick(2);
      check_mem("held_req_start", 1'b1, 6'd7);
      tick(10);
      check_mem("held_req_10", 1'b1, 6'd7);
      check_display("held_old_word", 8'hB0, 4'hD);

      // Address moves during the request; the outstanding one completes first.
      apply_stimulus(6'd9, 1'b1, 1'b0, 32'h1234ABCD);
      tick(1);
      check_mem("addr_change_in_req", 1'b1, 6'd7);
      apply_stimulus(6'd9, 1'b1, 1'b1, 32'h0000FFFF);
      tick(1);
      check_mem("grant_old_addr", 1'b0, 6'd7);
      apply_stimulus(6'd9, 1'b0, 1'b0, 32'h0000FFFF);
      tick(1);
      check_mem("rereq_new_addr", 1'b1, 6'd9);
      check_display("ffff_d1", 8'h8E, 4'hD);
      tick(5);
      check_display("ffff_d3", 8'h8E, 4'h7);
      check_output("rereq_held", 32'(mem_bus.mem_req), 32'd1);

      apply_stimulus(6'd9, 1'b0, 1'b1, 32'h0000FFFF);
      tick(1);
      check_mem("rereq_granted", 1'b0, 6'd9);
      apply_stimulus(6'd9, 1'b0, 1'b1, 32'h00000000);

      // Refetch every REFETCH_FRAMES * 4 * REFRESH_DIV = 32 clocks with no address change.
      tick(18);
      check_output("refetch_idle_before", 32'(mem_bus.mem_req), 32'd0);
      check_display("refetch_old_word", 8'h8E, 4'h7);
      tick(1);
      check_mem("refetch_req", 1'b1, 6'd9);
      check_display("refetch_still_old", 8'h8E, 4'hE);
      tick(1);
      check_output("refetch_granted", 32'(mem_bus.mem_req), 32'd0);
      tick(1);
      check_display("zero_word_d0", 8'hC0, 4'hE);
      tick(29);
      check_output("refetch2_idle_before", 32'(mem_bus.mem_req), 32'd0);
      tick(1);
      check_mem("refetch2_req", 1'b1, 6'd9);
      tick(1);
      check_output("refetch2_granted", 32'(mem_bus.mem_req), 32'd0);

      // Asynchronous reset while digit 2 is lit, between clock edges.
      tick(7);
      check_display("pre_reset_d2", 8'hC0, 4'hB);
      #4;
      rst_n = 1'b0;
      #1;
      check_display("async_reset", 8'hFF, 4'hF);
      check_mem("async_reset", 1'b0, 6'd0);
      #1;
      rst_n = 1'b1;
      tick(1);
      check_display("restart_d0", 8'hC0, 4'hE);
      check_mem("restart_req", 1'b1, 6'd9);
      tick(1);
      check_output("restart_granted", 32'(mem_bus.mem_req), 32'd0);
      tick(3);
      check_display("restart_d1", 8'hC0, 4'hD);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
